// File: rtl/gups_mem_responder.sv
// gups_mem_responder
// Memory-side responder for the GUPS request interface. Holds a local
// 2^AW x 64-bit memory that is swept to zero after every reset, then serves
// single-word reads and writes with a fixed LATENCY (0..15) between capture
// and a one-cycle ready pulse.
//
// Handshake: the initiator raises req with write/address/wdata valid and
// holds req until it sees ready; the request is captured on the first IDLE
// cycle with req=1, and ready is high for exactly one cycle, LATENCY+1 cycles
// after that capture cycle. Dropping req while waiting aborts the request
// (no ready, no memory write). req still high after ready is a new request.
//
// Optional feature macro: GUPS_MEM_STATS_EN adds rd_count / wr_count.
// state_dbg exposes the FSM state (CLEAR=0, IDLE=1, WAIT=2, RESP=3).
module gups_mem_responder #(
  parameter int AW      = 10,
  parameter int LATENCY = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req,
  input  logic        write,
  input  logic [63:0] address,
  input  logic [63:0] wdata,
  output logic [63:0] rdata,
  output logic        ready,
  output logic        busy,
`ifdef GUPS_MEM_STATS_EN
  output logic [31:0] rd_count,
  output logic [31:0] wr_count,
`endif
  output logic [1:0]  state_dbg
);

  typedef enum logic [1:0] {S_CLEAR, S_IDLE, S_WAIT, S_RESP} state_t;

  state_t          state, state_nx;
  logic [AW-1:0]   ptr;
  logic [3:0]      cnt;
  logic [AW-1:0]   addr_q;
  logic            wr_q;
  logic [63:0]     wdata_q;
  logic [63:0]     mem [0:(1<<AW)-1];

  // Memory operation committed on the edge that enters RESP
  logic            op_go;
  logic            op_wr;
  logic [AW-1:0]   op_addr;
  logic [63:0]     op_wdata;

  // Upper address bits are ignored by design (address aliasing)
  logic            unused_addr_bits;
  assign unused_addr_bits = ^address[63:AW];

  // Next-state logic; with LATENCY=0 the operation uses the inputs directly
  // because capture and commit happen on the same edge
  always_comb begin
    state_nx = state;
    op_go    = 1'b0;
    op_wr    = wr_q;
    op_addr  = addr_q;
    op_wdata = wdata_q;
    case (state)
      S_CLEAR: if (ptr == '1) state_nx = S_IDLE;
      S_IDLE: begin
        if (req) begin
          if (LATENCY == 0) begin
            state_nx = S_RESP;
            op_go    = 1'b1;
            op_wr    = write;
            op_addr  = address[AW-1:0];
            op_wdata = wdata;
          end else begin
            state_nx = S_WAIT;
          end
        end
      end
      S_WAIT: begin
        if (!req) begin
          state_nx = S_IDLE;
        end else if (cnt == 4'd1) begin
          state_nx = S_RESP;
          op_go    = 1'b1;
        end
      end
      S_RESP:  state_nx = S_IDLE;
      default: state_nx = S_CLEAR;
    endcase
  end

  // FSM state register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= S_CLEAR;
    else        state <= state_nx;
  end

  // Clear pointer, request capture and latency counter
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ptr     <= '0;
      cnt     <= '0;
      addr_q  <= '0;
      wr_q    <= 1'b0;
      wdata_q <= '0;
    end else begin
      if (state == S_CLEAR) ptr <= ptr + 1'b1;
      if (state == S_IDLE && req) begin
        addr_q  <= address[AW-1:0];
        wr_q    <= write;
        wdata_q <= wdata;
        cnt     <= 4'(LATENCY);
      end else if (state == S_WAIT) begin
        cnt <= cnt - 4'd1;
      end
    end
  end

  // Memory array: zero sweep during CLEAR, committed writes otherwise
  always_ff @(posedge clk) begin
    if (state == S_CLEAR)    mem[ptr]     <= '0;
    else if (op_go && op_wr) mem[op_addr] <= op_wdata;
  end

  // Registered read data, held until the next read completes
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)               rdata <= '0;
    else if (op_go && !op_wr) rdata <= mem[op_addr];
  end

`ifdef GUPS_MEM_STATS_EN
  // Completed-request counters, bumped once per RESP cycle
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rd_count <= '0;
      wr_count <= '0;
    end else if (state == S_RESP) begin
      if (wr_q) wr_count <= wr_count + 32'd1;
      else      rd_count <= rd_count + 32'd1;
    end
  end
`endif

  assign ready     = (state == S_RESP);
  assign busy      = (state == S_CLEAR);
  assign state_dbg = state;

endmodule

// File: doc/gups_mem_responder.md
# gups_mem_responder

Memory-side responder for the GUPS request interface: accepts single-word read and write requests from a `gups` initiator and returns data with a `ready` pulse after a fixed, programmable latency. It holds a local 64-bit word memory that is zero-cleared after reset, so the random read-modify-write traffic produces deterministic results. It sits directly opposite `gups`: the initiator's `address/dout/req/write` drive this block, and this block's `rdata/ready` return to the initiator's `data_in/ready`.

## Interface

Parameters:
- `AW`, 10, word-address width; memory depth is 2^AW 64-bit words.
- `LATENCY`, 2, wait cycles between request capture and `ready`; legal range 0–15.

Ports:
- `clk`  in  1  single clock, rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `req`  in  1  request valid; held high by the initiator until `ready` is seen.
- `write`  in  1  1 = write `wdata`, 0 = read.
- `address`  in  64  word address; only `address[AW-1:0]` is used, and upper bits are ignored.
- `wdata`  in  64  write data.
- `rdata`  out  64  read data, registered.
- `ready`  out  1  one-cycle completion pulse.
- `busy`  out  1  high while the post-reset clear sweep runs.
- `rd_count`  out  32  completed reads (only with `GUPS_MEM_STATS_EN`).
- `wr_count`  out  32  completed writes (only with `GUPS_MEM_STATS_EN`).

## Operation

- **States:** CLEAR, IDLE, WAIT, RESP.
- **Reset (`reset`=0):** asynchronous entry into CLEAR.
  - Clear pointer = 0, `ready`=0, `rdata`=0, `busy`=1, counters = 0.
  - Memory contents are not reset asynchronously.
- **CLEAR:**
  - Writes 0 to `mem[ptr]` and increments `ptr` each cycle.
  - After writing word 2^AW−1, goes to IDLE and drops `busy`.
  - `req` is ignored during CLEAR; the initiator simply waits.
- **IDLE:**
  - If `req`=1, captures `address[AW-1:0]`, `write` and `wdata` and loads the latency counter with `LATENCY`.
  - Goes to WAIT, or straight to RESP when `LATENCY`=0.
- **WAIT:**
  - Counter decrements each cycle; goes to RESP when it reaches 0.
  - If `req` falls in WAIT, this is an abort: return to IDLE, no `ready`, no memory write.
- **RESP:** `ready`=1 for exactly this cycle, then unconditionally IDLE.
  - Read: `rdata` = `mem[captured addr]`, loaded on the edge entering RESP.
  - Write: `mem[captured addr]` ← captured `wdata` on the edge entering RESP; `rdata` holds its previous value.
- **Request decode:** only the captured copy of `address/write/wdata` is used. Input changes after capture have no effect, except `req` falling (abort).
- **Read-modify-write sequence:** the initiator holds `req`, flips `write` to 1 on the `ready` edge, and the responder re-captures in IDLE on the next cycle. A write followed by a read of the same word returns the written value; no bypass hazard exists because the write commits before IDLE.
- **Back-to-back requests:** `req` still high in the IDLE cycle after RESP is treated as a new request.
- **Reset mid-operation:** any in-flight request is dropped with no `ready` and no write, and the clear sweep restarts from 0.

## Timing

- **Capture:** occurs at the edge ending cycle T, where T is an IDLE cycle with `req`=1.
- **Latency:** `ready` is high in cycle T+1+LATENCY. With `LATENCY`=2, capture edge at T, `ready` is high in T+3.
- **Minimum transaction period:** LATENCY+2 cycles (IDLE + WAIT×LATENCY + RESP).
- **`rdata`:** valid in the `ready` cycle and held until the next read completes.
- **Clear sweep:** `busy` is high for exactly 2^AW cycles after reset deasserts; the first request can be captured in cycle 2^AW.

## Configuration

- **`GUPS_MEM_STATS_EN` defined:**
  - `rd_count` and `wr_count` ports exist.
  - Each increments by 1 in every RESP cycle of its type and wraps modulo 2^32.
  - Aborted requests are not counted; both counters reset to 0.
- **`GUPS_MEM_STATS_EN` undefined:** the ports and counters are absent. All other behaviour is identical.

## Test plan

- **Reset and clear:** apply reset, release, then read words 0, 5 and 1023 (AW=10) → `busy` high for 1024 cycles, each read returns 0, `ready` at capture+3.
- **Read-modify-write:** drive a `gups` instance with seed 0x1234 → each read returns prior value v, the following write stores v+1. After two passes over the same address, the final read returns 2.
- **Latency sweep:** `LATENCY`=0, 1 and 15 → `ready` exactly 1, 2 and 16 cycles after capture, and never longer than one cycle.
- **Abort:** raise `req`, drop it in WAIT, with write of 0xDEAD to word 7 → no `ready`; a subsequent read of word 7 returns 0.
- **Address aliasing:** write 0xAA to address 0x1_0000_0003, then read address 0x3 → returns 0xAA.
- **Reset mid-transaction and stats:** assert reset during WAIT → `ready` stays 0, sweep restarts, `busy` high for 1024 cycles. With `GUPS_MEM_STATS_EN`, 3 reads and 2 writes give `rd_count`=3, `wr_count`=2, and the counters are 0 after reset.
